// File: rtl/mips_pkg.sv
// mips_pkg: shared word type, default fetch queue depth and exception code constants.
package mips_pkg;
   typedef logic [31:0] word_t;
   localparam int FQ_DEPTH = 4;
   localparam logic [4:0] EXC_ADEL = 5'd4;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x W register-file storage, one synchronous write port and one async read port.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int W = 64,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (!reset)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch FIFO between fetch and decode with flush.
// FETCH_ALIGN_CHECK_EN adds a per-entry misaligned-PC flag presented on out_exc.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_instr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_instr,
   output logic          out_exc,
   input  logic          flush,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
`ifdef FETCH_ALIGN_CHECK_EN
   localparam int W = 65;
`else
   localparam int W = 64;
`endif
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;
   logic [W-1:0]  wdata, rdata;
   word_t         head_pc, head_instr;
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
`ifdef FETCH_ALIGN_CHECK_EN
   assign wdata   = {in_pc[1:0] != 2'b00, in_pc, in_instr};
   assign out_exc = rdata[64];
`else
   assign wdata   = {in_pc, in_instr};
   assign out_exc = 1'b0;
`endif
   assign {head_pc, head_instr} = rdata[63:0];
   assign out_pc    = head_pc;
   assign out_instr = head_instr;
   // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
   always_ff @(posedge clk)
      if (!reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   fetch_queue_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
      .clk(clk),
      .reset(reset),
      .we(push && !flush),
      .waddr(wr_ptr),
      .wdata(wdata),
      .raddr(rd_ptr),
      .rdata(rdata)
   );
endmodule
